pwm_sample_demod: RTL and testbench
===================================

// Module: pwm_sample_demod
// PURPOSE
//  Receive side of the 8-bit PWM audio/DAC link. Recovers the sample value from
//  an incoming PWM stream of fixed frame length PERIOD clocks (one high run of
//  'sample' cycles per frame, then low for the rest of the frame). Sits at a
//  PMOD input pin and feeds recovered samples to loopback checking or display
//  logic. Also flags lock and frame errors.
// PARAMETERS
//  SAMPLE_W  8    sample width; PERIOD = 2**SAMPLE_W
//  TOL       2    accepted frame-length deviation, +/- clocks
//  SYNC_N    2    input synchroniser depth (flops), >= 2
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous active-low reset
//  pwm_in        in   1         asynchronous PWM input pin
//  sample_out    out  SAMPLE_W  last recovered sample, held between updates
//  sample_valid  out  1         1-cycle strobe: sample_out updated this cycle
//  locked        out  1         1 = last frame length was within PERIOD +/- TOL
//  frame_err     out  1         1-cycle strobe: frame length out of tolerance
// BEHAVIOUR
//  Reset: all outputs 0, FSM = SEARCH, counters 0, synchroniser flops 0.
//   Reset is asynchronous assert and synchronous deassert via rst_n as given.
//  Input: pwm_in passes through SYNC_N flops -> pwm_s; pwm_d = pwm_s delayed 1.
//   rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
//  Counters, width SAMPLE_W+2, saturating (never wrap):
//   hi_cnt  = pwm_s-high cycles since last rise, rise cycle included.
//   per_cnt = cycles since last rise, rise cycle counted as 1.
//   idle_cnt = cycles since last edge of either kind.
//  FSM:
//   SEARCH: wait for rise -> HIGH, hi_cnt=1, per_cnt=1. No output.
//   HIGH: hi_cnt++, per_cnt++ each cycle; fall -> LOW.
//   LOW: per_cnt++; rise -> evaluate frame, hi_cnt=1, per_cnt=1, go to HIGH.
//  Frame evaluation, on the rise cycle, registered, visible the next cycle:
//   |per_cnt - PERIOD| <= TOL: sample_out = min(hi_cnt, 2**SAMPLE_W-1),
//    sample_valid=1, locked=1.
//   Otherwise: frame_err=1, locked=0, sample_out unchanged, no valid strobe.
//  The first rise after SEARCH never produces a sample. The first valid sample
//   appears 1 cycle after the second rise.
//  Constant-level handling, covering duty 0 and full duty:
//   When idle_cnt reaches PERIOD+TOL -> sample_out = 0 if pwm_s==0, else
//    2**SAMPLE_W-1; sample_valid=1; locked unchanged; FSM -> SEARCH;
//    idle_cnt=0. This repeats every PERIOD+TOL cycles while the level holds.
//  Simultaneous events: an edge on the same cycle as the idle timeout wins, and
//   the timeout is suppressed. Edges occur at most 1 per cycle by construction.
//  A glitch-high (rise then fall next cycle) is a valid frame start with
//   hi_cnt=1. No extra filtering is applied.
//  Latency: pwm_in to pwm_s is SYNC_N cycles, plus 1 cycle for the registered
//   outputs after the detecting edge.
//  Reset mid-frame: all state is discarded immediately. After release the block
//   restarts in SEARCH, and the partial frame never yields a sample.
// TESTING
//  1 Drive pmod-style PWM, s=0x80, period 256, 4 frames -> 0 valid on first
//    rise; then sample_out=0x80 with one valid strobe per frame; locked=1.
//  2 Drive s=0x00 (constant low) -> a valid strobe with sample_out=0x00 every
//    258 cycles; frame_err never asserts.
//  3 Drive s=0xFF (255 high, 1 low) -> sample_out=0xFF each frame, locked=1.
//    Then hold high -> 0xFF via timeout after 258 cycles.
//  4 Frame length 300 with 128 high -> frame_err strobe, locked=0, sample_out
//    keeps its prior value. Return to 256 -> locked=1 after 1 good frame.
//  5 Change s 0x10 -> 0xF0 between frames -> sample_out steps 0x10 then 0xF0,
//    with exactly 1 valid per frame and no error.
//  6 Assert rst_n=0 mid-HIGH for 3 cycles -> outputs 0 asynchronously. After
//    release, first valid only after 2 further rises, with a correct value.

Source files
------------

// File: rtl/pwm_sample_demod_if.sv
// Signal bundle between a PWM link pin and the sample demodulator.
// master drives the pin and consumes samples; slave is the demodulator.
interface pwm_sample_demod_if #(
    parameter int SAMPLE_W = 8
);
    logic                pwm_in;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                locked;
    logic                frame_err;

    modport master (
        output pwm_in,
        input  sample_out,
        input  sample_valid,
        input  locked,
        input  frame_err
    );

    modport slave (
        input  pwm_in,
        output sample_out,
        output sample_valid,
        output locked,
        output frame_err
    );
endinterface

// File: rtl/pwm_sample_demod.sv
// Recovers 8-bit samples from a fixed-period PWM stream by measuring the high
// run between consecutive rising edges; flags lock, frame errors and flat levels.
module pwm_sample_demod #(
    parameter int SAMPLE_W = 8,
    parameter int TOL      = 2,
    parameter int SYNC_N   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_sample_demod_if.slave bus
);
    localparam int CNT_W  = SAMPLE_W + 2;
    localparam int PERIOD = 1 << SAMPLE_W;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PER_MIN      = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] PER_MAX      = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(PERIOD + TOL - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CLAMP = CNT_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_HIGH,
        ST_LOW
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [SYNC_N-1:0]   sync_q;
    logic                pwm_s;
    logic                pwm_d_q;
    logic                rise;
    logic                fall;
    logic                timeout;
    logic                frame_ok;
    logic [SAMPLE_W-1:0] hi_clamped;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    hi_cnt_q,   hi_cnt_d;
    logic [CNT_W-1:0]    per_cnt_q,  per_cnt_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [SAMPLE_W-1:0] sample_q,   sample_d;
    logic                valid_q,    valid_d;
    logic                locked_q,   locked_d;
    logic                err_q,      err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_N-2:0], bus.pwm_in};
            pwm_d_q <= pwm_s;
        end
    end

    assign pwm_s      = sync_q[SYNC_N-1];
    assign rise       = pwm_s & ~pwm_d_q;
    assign fall       = ~pwm_s & pwm_d_q;
    // Any edge restarts the flat-level timer, so an edge landing on the
    // timeout cycle takes precedence.
    assign timeout    = ~rise & ~fall & (idle_cnt_q == IDLE_LAST);
    assign frame_ok   = (per_cnt_q >= PER_MIN) && (per_cnt_q <= PER_MAX);
    assign hi_clamped = (hi_cnt_q > SAMPLE_CLAMP) ? '1 : hi_cnt_q[SAMPLE_W-1:0];

    always_comb begin
        state_d    = state_q;
        hi_cnt_d   = hi_cnt_q;
        per_cnt_d  = per_cnt_q;
        idle_cnt_d = (rise | fall | timeout) ? '0 : sat_inc(idle_cnt_q);
        sample_d   = sample_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        err_d      = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (rise) begin
                    state_d   = ST_HIGH;
                    hi_cnt_d  = CNT_ONE;
                    per_cnt_d = CNT_ONE;
                end
            end
            ST_HIGH: begin
                per_cnt_d = sat_inc(per_cnt_q);
                if (pwm_s) begin
                    hi_cnt_d = sat_inc(hi_cnt_q);
                end
                if (fall) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    // The rise closes the previous frame: judge its length
                    // before the counters restart for the new one.
                    if (frame_ok) begin
                        sample_d = hi_clamped;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                    end
                    state_d   = ST_HIGH;
                    hi_cnt_d  = CNT_ONE;
                    per_cnt_d = CNT_ONE;
                end else begin
                    per_cnt_d = sat_inc(per_cnt_q);
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        // A flat line is duty 0 or full duty; report it and resynchronise.
        if (timeout) begin
            state_d  = ST_SEARCH;
            sample_d = {SAMPLE_W{pwm_s}};
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SEARCH;
            hi_cnt_q   <= '0;
            per_cnt_q  <= '0;
            idle_cnt_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_cnt_q   <= hi_cnt_d;
            per_cnt_q  <= per_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.frame_err    = err_q;
endmodule

// File: tb/tb_pwm_sample_demod.sv
// Randomised and directed PWM stimulus for pwm_sample_demod, checked every
// cycle against a timestamp-based frame model plus hand-computed checkpoints.
module tb_pwm_sample_demod;
    localparam int SAMPLE_W = 8;
    localparam int TOL      = 2;
    localparam int SYNC_N   = 2;
    localparam int PERIOD   = 1 << SAMPLE_W;
    localparam int HIST_N   = 65536;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pwm_sample_demod_if #(.SAMPLE_W(SAMPLE_W)) bus ();

    pwm_sample_demod #(
        .SAMPLE_W(SAMPLE_W),
        .TOL     (TOL),
        .SYNC_N  (SYNC_N)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  vcnt  = 0;
    int  ecnt  = 0;
    bit  chk_en = 1'b0;

    // Model state: the level seen after the synchroniser is the pin sampled
    // SYNC_N clocks earlier; frames are judged from rise timestamps.
    logic [SYNC_N-1:0]   dl = '0;
    bit                  prev = 1'b0;
    bit                  armed = 1'b0;
    int                  t_rise = 0;
    int                  t_quiet = 0;
    int                  cyc = 0;
    bit                  hist [HIST_N];
    logic [SAMPLE_W-1:0] exp_sample = '0;
    logic                exp_valid = 1'b0;
    logic                exp_locked = 1'b0;
    logic                exp_err = 1'b0;

    always @(posedge clk) begin : model
        bit s;
        bit rise;
        bit fall;
        int len;
        int dev;
        int highs;
        if (!rst_n) begin
            dl         = '0;
            prev       = 1'b0;
            armed      = 1'b0;
            t_quiet    = cyc;
            exp_sample = '0;
            exp_valid  = 1'b0;
            exp_locked = 1'b0;
            exp_err    = 1'b0;
        end else begin
            s    = dl[SYNC_N-1];
            dl   = {dl[SYNC_N-2:0], bus.pwm_in};
            rise = s & ~prev;
            fall = ~s & prev;
            if (cyc < HIST_N) hist[cyc] = s;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (rise) begin
                if (armed) begin
                    len   = cyc - t_rise;
                    highs = 0;
                    for (int k = t_rise; k < cyc; k++) highs += int'(hist[k]);
                    dev = len - PERIOD;
                    if (dev < 0) dev = -dev;
                    if (dev <= TOL) begin
                        exp_sample = (highs > PERIOD - 1) ? '1 : SAMPLE_W'(highs);
                        exp_valid  = 1'b1;
                        exp_locked = 1'b1;
                    end else begin
                        exp_err    = 1'b1;
                        exp_locked = 1'b0;
                    end
                end
                armed   = 1'b1;
                t_rise  = cyc;
                t_quiet = cyc;
            end else if (fall) begin
                t_quiet = cyc;
            end else if (cyc - t_quiet == PERIOD + TOL) begin
                exp_sample = s ? '1 : '0;
                exp_valid  = 1'b1;
                armed      = 1'b0;
                t_quiet    = cyc;
            end
            prev = s;
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        logic [SAMPLE_W-1:0] r_sample;
        logic                r_valid;
        logic                r_locked;
        logic                r_err;
        if (chk_en) begin
            if (!rst_n) begin
                r_sample = '0; r_valid = 1'b0; r_locked = 1'b0; r_err = 1'b0;
            end else begin
                r_sample = exp_sample; r_valid = exp_valid;
                r_locked = exp_locked; r_err = exp_err;
            end
            n_cmp++;
            if (bus.sample_out !== r_sample || bus.sample_valid !== r_valid ||
                bus.locked !== r_locked || bus.frame_err !== r_err) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got sample=%0d valid=%0b locked=%0b err=%0b, required sample=%0d valid=%0b locked=%0b err=%0b",
                         $time, bus.sample_out, bus.sample_valid, bus.locked, bus.frame_err,
                         r_sample, r_valid, r_locked, r_err);
            end
            if (rst_n) begin
                vcnt += int'(bus.sample_valid);
                ecnt += int'(bus.frame_err);
            end
        end
    end

    task automatic pin(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input bit lvl, input int n);
        bus.pwm_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int len, input int hi);
        if (hi > 0) drive(1'b1, hi);
        if (len - hi > 0) drive(1'b0, len - hi);
    endtask

    function automatic int outs_word();
        return int'({bus.sample_out, bus.sample_valid, bus.locked, bus.frame_err});
    endfunction

    initial begin : stim
        int v0;
        int e0;
        int kind;
        int len;
        int hi;
        bus.pwm_in = 1'b0;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        pin("reset_outputs", outs_word(), 0);
        drive(1'b0, 10);

        // 0x80 frames: the first rise only arms the receiver
        v0 = vcnt; e0 = ecnt;
        repeat (5) frame(PERIOD, 8'h80);
        pin("s80_valids", vcnt - v0, 4);
        pin("s80_sample", int'(bus.sample_out), 8'h80);
        pin("s80_locked", int'(bus.locked), 1);
        pin("s80_errs", ecnt - e0, 0);

        // duty 0: one timeout sample every PERIOD+TOL clocks
        v0 = vcnt; e0 = ecnt;
        drive(1'b0, 800);
        pin("duty0_valids", vcnt - v0, 3);
        pin("duty0_sample", int'(bus.sample_out), 0);
        pin("duty0_errs", ecnt - e0, 0);

        // full duty, then held high
        v0 = vcnt; e0 = ecnt;
        repeat (4) frame(PERIOD, 255);
        drive(1'b1, 600);
        pin("dutyff_valids", vcnt - v0, 6);
        pin("dutyff_sample", int'(bus.sample_out), 8'hFF);
        pin("dutyff_locked", int'(bus.locked), 1);
        pin("dutyff_errs", ecnt - e0, 0);

        // over-long frame loses lock, one good frame regains it
        drive(1'b0, 100);
        v0 = vcnt; e0 = ecnt;
        frame(PERIOD, 128);
        frame(300, 128);
        drive(1'b1, 10);
        pin("long_errs", ecnt - e0, 1);
        pin("long_valids", vcnt - v0, 1);
        pin("long_locked", int'(bus.locked), 0);
        pin("long_sample_kept", int'(bus.sample_out), 128);
        drive(1'b1, 118);
        drive(1'b0, 128);
        drive(1'b1, 10);
        pin("relock_locked", int'(bus.locked), 1);
        pin("relock_valids", vcnt - v0, 2);
        drive(1'b1, 118);
        drive(1'b0, 128);

        // step 0x10 -> 0xF0
        v0 = vcnt; e0 = ecnt;
        repeat (3) frame(PERIOD, 8'h10);
        pin("step_lo_sample", int'(bus.sample_out), 8'h10);
        pin("step_lo_valids", vcnt - v0, 3);
        repeat (3) frame(PERIOD, 8'hF0);
        drive(1'b1, 10);
        pin("step_hi_sample", int'(bus.sample_out), 8'hF0);
        pin("step_hi_valids", vcnt - v0, 7);
        pin("step_errs", ecnt - e0, 0);

        // asynchronous reset in the middle of a high run
        drive(1'b1, 40);
        #2 rst_n = 1'b0;
        #1 pin("async_reset_outputs", outs_word(), 0);
        bus.pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        v0 = vcnt; e0 = ecnt;
        drive(1'b0, 150);
        frame(PERIOD, 8'h40);
        pin("post_reset_no_valid", vcnt - v0, 0);
        repeat (2) frame(PERIOD, 8'h40);
        pin("post_reset_valids", vcnt - v0, 2);
        pin("post_reset_sample", int'(bus.sample_out), 8'h40);
        pin("post_reset_locked", int'(bus.locked), 1);

        // random frames, bad lengths, glitches and flat runs
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(260, 600)));
            end else begin
                if (kind == 1) begin
                    if ($urandom_range(0, 1) == 1) len = PERIOD + int'($urandom_range(3, 20));
                    else len = PERIOD - int'($urandom_range(3, 20));
                end else begin
                    len = PERIOD - TOL + int'($urandom_range(0, 2 * TOL));
                end
                case ($urandom_range(0, 5))
                    0:       hi = 1;
                    1:       hi = len - 1;
                    default: hi = int'($urandom_range(1, len - 1));
                endcase
                frame(len, hi);
            end
        end
        drive(1'b0, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
